regwb_arbiter: RTL and testbench

REGWB_ARBITER -- requirements
Module: regwb_arbiter

---
 rtl/mips_pkg.sv | 7 +
 rtl/regwb_skid.sv | 32 +++
 rtl/regwb_arbiter.sv | 76 +++++++
 tb/tb_regwb_arbiter.sv | 138 +++++++++++++
 4 files changed

// File: rtl/mips_pkg.sv
// mips_pkg: shared widths, zero-register index and writeback arbiter FSM states.
package mips_pkg;
  localparam int REG_IDX_W = 5;
  localparam int DATA_W = 32;
  localparam logic [REG_IDX_W-1:0] ZERO_REG = 5'd0;
  typedef enum logic {PRI_ALU = 1'b0, PRI_MEM = 1'b1} priState_t;
endpackage

// File: rtl/regwb_skid.sv
// regwb_skid: one-entry skid buffer; Ready depends only on occupancy (and Reset), never on Valid.
module regwb_skid
  import mips_pkg::*;
(
  input  logic                 Clk,
  input  logic                 Reset,
  input  logic                 InValid,
  input  logic [REG_IDX_W-1:0] InReg,
  input  logic [DATA_W-1:0]    InData,
  output logic                 InReady,
  output logic                 OutValid,
  output logic [REG_IDX_W-1:0] OutReg,
  output logic [DATA_W-1:0]    OutData,
  input  logic                 OutTake
);
  logic full;
  assign InReady = !full && !Reset;
  assign OutValid = full;
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      full <= 1'b0;
      OutReg <= '0;
      OutData <= '0;
    end else if (InValid && InReady) begin
      full <= 1'b1;
      OutReg <= InReg;
      OutData <= InData;
    end else if (OutTake) begin
      full <= 1'b0;
    end
  end
endmodule

// File: rtl/regwb_arbiter.sv
// regwb_arbiter: round-robin arbiter merging ALU and load writebacks onto one register-file port.
// Define REGWB_SKID_EN to insert a one-entry skid buffer per requester (registered Ready, 2-cycle latency).
module regwb_arbiter
  import mips_pkg::*;
#(
  parameter int CNT_W = 16
) (
  input  logic                 Clk,
  input  logic                 Reset,
  input  logic                 AluValid,
  input  logic [REG_IDX_W-1:0] AluReg,
  input  logic [DATA_W-1:0]    AluData,
  output logic                 AluReady,
  input  logic                 MemValid,
  input  logic [REG_IDX_W-1:0] MemReg,
  input  logic [DATA_W-1:0]    MemData,
  output logic                 MemReady,
  output logic                 RegWrite,
  output logic [REG_IDX_W-1:0] WriteReg,
  output logic [DATA_W-1:0]    WriteData,
  output logic [1:0]           Grant,
  output logic [CNT_W-1:0]     ConflictCount
);
  priState_t state, stateNext;
  logic aluReq, memReq, grantAlu, grantMem;
  logic [REG_IDX_W-1:0] aluReg, memReg, selReg;
  logic [DATA_W-1:0] aluData, memData, selData;
`ifdef REGWB_SKID_EN
  regwb_skid uAluSkid (
    .Clk(Clk), .Reset(Reset), .InValid(AluValid), .InReg(AluReg), .InData(AluData), .InReady(AluReady),
    .OutValid(aluReq), .OutReg(aluReg), .OutData(aluData), .OutTake(grantAlu)
  );
  regwb_skid uMemSkid (
    .Clk(Clk), .Reset(Reset), .InValid(MemValid), .InReg(MemReg), .InData(MemData), .InReady(MemReady),
    .OutValid(memReq), .OutReg(memReg), .OutData(memData), .OutTake(grantMem)
  );
`else
  assign aluReq = AluValid;
  assign aluReg = AluReg;
  assign aluData = AluData;
  assign memReq = MemValid;
  assign memReg = MemReg;
  assign memData = MemData;
  assign AluReady = grantAlu;
  assign MemReady = grantMem;
`endif
  // A lone requester always wins; the priority state only breaks ties.
  always_comb begin
    grantAlu = !Reset && aluReq && (!memReq || state == PRI_ALU);
    grantMem = !Reset && memReq && !grantAlu;
    selReg = grantAlu ? aluReg : memReg;
    selData = grantAlu ? aluData : memData;
    stateNext = grantAlu ? PRI_MEM : grantMem ? PRI_ALU : state;
  end
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) state <= PRI_ALU;
    else state <= stateNext;
  end
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      RegWrite <= 1'b0;
      WriteReg <= '0;
      WriteData <= '0;
      Grant <= '0;
      ConflictCount <= '0;
    end else begin
      RegWrite <= (grantAlu || grantMem) && selReg != ZERO_REG;
      if (grantAlu || grantMem) begin
        WriteReg <= selReg;
        WriteData <= selData;
        Grant <= {grantMem, grantAlu};
      end
      if (aluReq && memReq && !(&ConflictCount)) ConflictCount <= ConflictCount + 1'b1;
    end
  end
endmodule

// File: tb/tb_regwb_arbiter.sv
// tb_regwb_arbiter: directed self-checking bench for regwb_arbiter (default build, CNT_W=4).
module tb_regwb_arbiter;
  logic Clk = 1'b0;
  logic Reset = 1'b1;
  logic AluValid = 1'b0, MemValid = 1'b0;
  logic [4:0] AluReg = '0, MemReg = '0;
  logic [31:0] AluData = '0, MemData = '0;
  logic AluReady, MemReady, RegWrite;
  logic [4:0] WriteReg;
  logic [31:0] WriteData;
  logic [1:0] Grant;
  logic [3:0] ConflictCount;
  int nChecks = 0;
  int nErrors = 0;

  regwb_arbiter #(.CNT_W(4)) dut (
    .Clk(Clk), .Reset(Reset),
    .AluValid(AluValid), .AluReg(AluReg), .AluData(AluData), .AluReady(AluReady),
    .MemValid(MemValid), .MemReg(MemReg), .MemData(MemData), .MemReady(MemReady),
    .RegWrite(RegWrite), .WriteReg(WriteReg), .WriteData(WriteData),
    .Grant(Grant), .ConflictCount(ConflictCount)
  );

  always #5 Clk = ~Clk;

  task automatic checkVal(input string tag, input logic [63:0] got, input logic [63:0] exp);
    nChecks++;
    if (got !== exp) begin
      nErrors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic setReq(input logic av, input logic [4:0] ar, input logic [31:0] ad,
                        input logic mv, input logic [4:0] mr, input logic [31:0] md);
    AluValid = av; AluReg = ar; AluData = ad;
    MemValid = mv; MemReg = mr; MemData = md;
  endtask

  initial begin
    setReq(1'b1, 5'd1, 32'h1, 1'b0, 5'd0, 32'h0);
    @(posedge Clk); #1;
    checkVal("rst_alu_ready", AluReady, 1'b0);
    checkVal("rst_regwrite", RegWrite, 1'b0);
    checkVal("rst_writereg", WriteReg, 5'd0);
    checkVal("rst_writedata", WriteData, 32'h0);
    checkVal("rst_grant", Grant, 2'b00);
    checkVal("rst_count", ConflictCount, 4'd0);
    @(negedge Clk);
    Reset = 1'b0;
    setReq(1'b1, 5'd5, 32'hDEADBEEF, 1'b0, 5'd0, 32'h0);
    #1;
    checkVal("single_alu_ready", AluReady, 1'b1);
    checkVal("single_mem_ready", MemReady, 1'b0);
    @(posedge Clk); #1;
    checkVal("single_regwrite", RegWrite, 1'b1);
    checkVal("single_writereg", WriteReg, 5'd5);
    checkVal("single_writedata", WriteData, 32'hDEADBEEF);
    checkVal("single_grant", Grant, 2'b01);
    @(negedge Clk);
    setReq(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);
    @(posedge Clk); #1;
    checkVal("idle_regwrite", RegWrite, 1'b0);
    checkVal("idle_hold_reg", WriteReg, 5'd5);
    checkVal("idle_hold_data", WriteData, 32'hDEADBEEF);
    // contention straight out of reset: ALU first, then Mem
    @(negedge Clk);
    Reset = 1'b1;
    @(negedge Clk);
    Reset = 1'b0;
    setReq(1'b1, 5'd3, 32'h1, 1'b1, 5'd4, 32'h2);
    #1;
    checkVal("cont_alu_ready", AluReady, 1'b1);
    checkVal("cont_mem_ready0", MemReady, 1'b0);
    @(posedge Clk); #1;
    checkVal("cont_wr0", {RegWrite, WriteReg, WriteData}, {1'b1, 5'd3, 32'h1});
    checkVal("cont_grant0", Grant, 2'b01);
    @(negedge Clk);
    AluValid = 1'b0;
    #1;
    checkVal("cont_mem_ready1", MemReady, 1'b1);
    @(posedge Clk); #1;
    checkVal("cont_wr1", {RegWrite, WriteReg, WriteData}, {1'b1, 5'd4, 32'h2});
    checkVal("cont_grant1", Grant, 2'b10);
    checkVal("cont_count", ConflictCount, 4'd1);
    // sustained contention alternates, neither side starves
    @(negedge Clk);
    setReq(1'b1, 5'd10, 32'hA, 1'b1, 5'd20, 32'hB);
    for (int i = 0; i < 6; i++) begin
      @(posedge Clk); #1;
      checkVal($sformatf("rr_grant%0d", i), Grant, (i % 2 == 0) ? 2'b01 : 2'b10);
      checkVal($sformatf("rr_reg%0d", i), WriteReg, (i % 2 == 0) ? 5'd10 : 5'd20);
    end
    checkVal("rr_count", ConflictCount, 4'd7);
    // zero register: accepted, no write strobe, Grant still updates
    @(negedge Clk);
    setReq(1'b0, 5'd0, 32'h0, 1'b1, 5'd0, 32'h7);
    #1;
    checkVal("zero_mem_ready", MemReady, 1'b1);
    @(posedge Clk); #1;
    checkVal("zero_regwrite", RegWrite, 1'b0);
    checkVal("zero_grant", Grant, 2'b10);
    // reset asserted in the accept cycle drops the request
    @(negedge Clk);
    setReq(1'b1, 5'd9, 32'h99, 1'b0, 5'd0, 32'h0);
    #2;
    Reset = 1'b1;
    #1;
    checkVal("midrst_alu_ready", AluReady, 1'b0);
    @(posedge Clk); #1;
    checkVal("midrst_outs", {RegWrite, WriteReg, WriteData, Grant, ConflictCount}, 44'h0);
    @(negedge Clk);
    setReq(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);
    Reset = 1'b0;
    @(posedge Clk); #1;
    checkVal("midrst_no_pulse", RegWrite, 1'b0);
    @(negedge Clk);
    setReq(1'b1, 5'd6, 32'h6, 1'b1, 5'd7, 32'h7);
    #1;
    checkVal("midrst_pri_alu", {AluReady, MemReady}, 2'b10);
    // saturation of the 4-bit conflict counter
    for (int i = 0; i < 20; i++) @(posedge Clk);
    #1;
    checkVal("sat_count", ConflictCount, 4'hF);
    @(posedge Clk); #1;
    checkVal("sat_no_wrap", ConflictCount, 4'hF);
    @(negedge Clk);
    setReq(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);
    $display("Simulation finished: %0d checks, %0d errors", nChecks, nErrors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1);
  end
endmodule
